// File: rtl/cflog_drain_if.sv
// Bundle of the drain engine's request, log-read, stream and status signals.
// master = the drain engine, slave = its surroundings (CFA monitor, log RAM, link).
interface cflog_drain_if;
  logic        flush;
  logic [15:0] cflow_log_ptr;
  logic        log_rd_en;
  logic [15:0] log_rd_addr;
  logic [15:0] log_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        drain_done;
  logic        log_clear;

  modport master (
    input  flush, cflow_log_ptr, log_rd_data, tx_ready,
    output log_rd_en, log_rd_addr, tx_data, tx_valid, busy, drain_done, log_clear
  );

  modport slave (
    output flush, cflow_log_ptr, log_rd_data, tx_ready,
    input  log_rd_en, log_rd_addr, tx_data, tx_valid, busy, drain_done, log_clear
  );
endinterface

// File: rtl/cflog_drain.sv
// CF-Log drain: snapshots the fill pointer, reads each 16-bit log word and streams
// a framed byte sequence (length header, words MSB first, XOR checksum).
module cflog_drain #(
  parameter logic [15:0] LOG_SIZE = 16'd256
) (
  input logic           clk,
  input logic           puc,
  cflog_drain_if.master bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HDR_HI  = 4'd1;
  localparam logic [3:0] S_HDR_LO  = 4'd2;
  localparam logic [3:0] S_RD_REQ  = 4'd3;
  localparam logic [3:0] S_RD_WAIT = 4'd4;
  localparam logic [3:0] S_TX_HI   = 4'd5;
  localparam logic [3:0] S_TX_LO   = 4'd6;
  localparam logic [3:0] S_CSUM    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [7:0]  csum_q, csum_d;

  logic        tx_vld;
  logic [7:0]  tx_byte;
  logic        hs;
  logic [16:0] idx_nxt;

  // Stream byte is a pure decode of state and held registers, so tx_ready never
  // reaches tx_data and the byte stays put while stalled.
  always_comb begin
    tx_vld  = 1'b1;
    tx_byte = '0;
    case (state_q)
      S_HDR_HI: tx_byte = n_q[15:8];
      S_HDR_LO: tx_byte = n_q[7:0];
      S_TX_HI:  tx_byte = word_q[15:8];
      S_TX_LO:  tx_byte = word_q[7:0];
      S_CSUM:   tx_byte = csum_q;
      default:  tx_vld  = 1'b0;
    endcase
  end

  assign hs      = tx_vld & bus.tx_ready;
  assign idx_nxt = {1'b0, idx_q} + 17'd1;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    word_d    = word_q;
    rd_addr_d = rd_addr_q;
    csum_d    = csum_q;
    if (hs && state_q != S_CSUM) csum_d = csum_q ^ tx_byte;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          state_d = S_HDR_HI;
          n_d     = (bus.cflow_log_ptr > LOG_SIZE) ? LOG_SIZE : bus.cflow_log_ptr;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_HDR_HI: if (hs) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (hs) begin
          if (n_q != '0) begin
            state_d   = S_RD_REQ;
            rd_addr_d = idx_q;
          end else begin
            state_d = S_CSUM;
          end
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        word_d  = bus.log_rd_data;
        state_d = S_TX_HI;
      end
      S_TX_HI: if (hs) state_d = S_TX_LO;
      S_TX_LO: begin
        if (hs) begin
          idx_d = idx_nxt[15:0];
          if (idx_nxt < {1'b0, n_q}) begin
            state_d   = S_RD_REQ;
            rd_addr_d = idx_nxt[15:0];
          end else begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM:  if (hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (puc) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      rd_addr_q <= '0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      rd_addr_q <= rd_addr_d;
      csum_q    <= csum_d;
    end
  end

  assign bus.tx_valid    = tx_vld;
  assign bus.tx_data     = tx_byte;
  assign bus.log_rd_en   = (state_q == S_RD_REQ);
  assign bus.log_rd_addr = rd_addr_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.drain_done  = (state_q == S_DONE);
  assign bus.log_clear   = (state_q == S_DONE);

endmodule

// File: tb/tb_cflog_drain.sv
// Directed bench for cflog_drain: behavioural log RAM plus per-scenario tasks.
module tb_cflog_drain;

  logic clk = 1'b0;
  logic puc = 1'b1;
  always #5 clk = ~clk;

  cflog_drain_if bus ();

  cflog_drain #(.LOG_SIZE(16'd256)) dut (
    .clk (clk),
    .puc (puc),
    .bus (bus)
  );

  logic [15:0] mem [0:1023];
  always @(posedge clk) if (bus.log_rd_en) bus.log_rd_data <= mem[bus.log_rd_addr[9:0]];

  int total = 0;
  int bad   = 0;

  int         c;
  int         done_c;
  int         stall_bad;
  int         clr_bad;
  logic [7:0] got [$];
  logic [7:0] expq [$];
  int         addrs [$];
  logic       stalled;
  logic [7:0] prev_data;
  logic [63:0] snap;

  function automatic void build_exp(input int n);
    logic [7:0] cs;
    logic [15:0] nn;
    expq.delete();
    nn = n[15:0];
    expq.push_back(nn[15:8]);
    expq.push_back(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      expq.push_back(mem[i][15:8]);
      expq.push_back(mem[i][7:0]);
    end
    cs = '0;
    foreach (expq[i]) cs = cs ^ expq[i];
    expq.push_back(cs);
  endfunction

  // Index of the first byte where got and expq differ over the first len bytes, else -1.
  function automatic int first_diff(input int len);
    for (int i = 0; i < len; i++) begin
      if (i >= got.size() || i >= expq.size()) return i;
      if (got[i] !== expq[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_frame(input logic [15:0] ptr, input bit bp, input int flush_at,
                           input int chg_at, input int abort_at, input int budget);
    @(posedge clk); #1;
    got.delete(); addrs.delete();
    c = -1; done_c = -1; stall_bad = 0; clr_bad = 0; stalled = 1'b0; prev_data = '0;
    bus.cflow_log_ptr = ptr;
    bus.flush = 1'b1;
    bus.tx_ready = 1'b1;
    for (int t = 0; t < budget; t++) begin
      @(posedge clk); #1;
      c++;
      bus.flush    = (c == flush_at);
      bus.tx_ready = bp ? (c % 3 == 0) : 1'b1;
      if (c == chg_at) bus.cflow_log_ptr = 16'h0002;
      puc = (c == abort_at);
      @(negedge clk);
      if (bus.drain_done) done_c = c;
      if (bus.log_clear !== bus.drain_done) clr_bad++;
      if (bus.log_rd_en) addrs.push_back(int'(bus.log_rd_addr));
      if (bus.tx_valid) begin
        if (stalled && bus.tx_data !== prev_data) stall_bad++;
        if (bus.tx_ready) got.push_back(bus.tx_data);
      end
      stalled   = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
      snap = {bus.tx_valid, bus.tx_data, bus.log_rd_en, bus.log_rd_addr,
              bus.busy, bus.drain_done, bus.log_clear};
      if (done_c >= 0) break;
      if (abort_at >= 0 && c == abort_at + 1) break;
    end
    bus.flush = 1'b0;
    puc = 1'b0;
  endtask

  task automatic test_reset;
    puc = 1'b1;
    bus.flush = 1'b1;
    bus.tx_ready = 1'b1;
    bus.cflow_log_ptr = 16'h0004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.tx_valid, bus.tx_data, bus.log_rd_en, bus.log_rd_addr, bus.busy,
         bus.drain_done, bus.log_clear} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h en=%b a=%h busy=%b done=%b clr=%b, want all 0",
               bus.tx_valid, bus.tx_data, bus.log_rd_en, bus.log_rd_addr, bus.busy,
               bus.drain_done, bus.log_clear);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    puc = 1'b0;
  endtask

  task automatic test_empty;
    int d;
    run_frame(16'h0000, 1'b0, -1, -1, -1, 20);
    build_exp(0);
    d = first_diff(3);
    total++;
    if (got.size() != 3 || d != -1) begin
      bad++;
      $display("FAIL empty_bytes: got %0d bytes (first diff %0d), want 3 bytes 00 00 00", got.size(), d);
    end
    total++;
    if (done_c !== 3) begin
      bad++;
      $display("FAIL empty_done_cycle: got %0d, want 3", done_c);
    end
    total++;
    if (addrs.size() != 0) begin
      bad++;
      $display("FAIL empty_no_read: got %0d reads, want 0", addrs.size());
    end
    total++;
    if (clr_bad != 0) begin
      bad++;
      $display("FAIL empty_clear_pulse: got %0d mismatches with drain_done, want 0", clr_bad);
    end
  endtask

  task automatic test_two_words;
    int d;
    run_frame(16'h0002, 1'b0, 5, -1, -1, 40);
    build_exp(2);
    d = first_diff(7);
    total++;
    if (got.size() != 7 || d != -1 || expq[6] !== 8'h16) begin
      bad++;
      $display("FAIL two_bytes: got %0d bytes (first diff %0d), want 00 02 E0 A2 E0 B6 16", got.size(), d);
    end
    total++;
    if (done_c !== 11) begin
      bad++;
      $display("FAIL two_done_cycle: got %0d, want 11", done_c);
    end
    total++;
    if (addrs.size() != 2 || addrs[0] != 0 || addrs[1] != 1) begin
      bad++;
      $display("FAIL two_rd_addrs: got %0d reads, want addresses 0 then 1", addrs.size());
    end
    // Mid-frame flush must not start a second frame once the first one ends.
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.log_rd_addr !== 16'h0001) begin
      bad++;
      $display("FAIL two_idle_after: got busy=%b addr=%h, want busy=0 addr=0001", bus.busy, bus.log_rd_addr);
    end
  endtask

  task automatic test_backpressure;
    int d;
    run_frame(16'h0002, 1'b1, -1, -1, -1, 80);
    build_exp(2);
    d = first_diff(7);
    total++;
    if (got.size() != 7 || d != -1) begin
      bad++;
      $display("FAIL bp_bytes: got %0d bytes (first diff %0d), want 7 matching bytes", got.size(), d);
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL bp_stable: got %0d data changes while stalled, want 0", stall_bad);
    end
    total++;
    if (addrs.size() != 2 || done_c < 0) begin
      bad++;
      $display("FAIL bp_reads: got %0d reads done_c=%0d, want 2 reads and completion", addrs.size(), done_c);
    end
  endtask

  task automatic test_clamp;
    int d;
    int seq_bad;
    run_frame(16'h0300, 1'b0, -1, 100, -1, 1200);
    build_exp(256);
    d = first_diff(515);
    total++;
    if (got.size() != 515 || d != -1 || got[0] !== 8'h01 || got[1] !== 8'h00) begin
      bad++;
      $display("FAIL clamp_bytes: got %0d bytes (first diff %0d), want 515 with header 01 00", got.size(), d);
    end
    seq_bad = 0;
    foreach (addrs[i]) if (addrs[i] != i) seq_bad++;
    total++;
    if (addrs.size() != 256 || seq_bad != 0) begin
      bad++;
      $display("FAIL clamp_addrs: got %0d reads with %0d out of order, want 256 reads 0..255", addrs.size(), seq_bad);
    end
    total++;
    if (done_c !== 1027) begin
      bad++;
      $display("FAIL clamp_done_cycle: got %0d, want 1027", done_c);
    end
  endtask

  task automatic test_abort_restart;
    int d;
    run_frame(16'h0008, 1'b0, 10, -1, 25, 40);
    build_exp(8);
    d = first_diff(14);
    total++;
    if (got.size() != 14 || d != -1) begin
      bad++;
      $display("FAIL abort_prefix: got %0d bytes (first diff %0d), want 14 matching bytes", got.size(), d);
    end
    total++;
    if (snap !== '0 || done_c != -1) begin
      bad++;
      $display("FAIL abort_outputs: got %h done_c=%0d, want 0 and no done", snap, done_c);
    end
    run_frame(16'h0002, 1'b0, -1, -1, -1, 40);
    build_exp(2);
    d = first_diff(7);
    total++;
    if (got.size() != 7 || d != -1 || addrs.size() != 2 || addrs[0] != 0) begin
      bad++;
      $display("FAIL restart_frame: got %0d bytes (first diff %0d), %0d reads, want 7 bytes and reads from 0",
               got.size(), d, addrs.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16'h9E37) ^ 16'h5A5A;
    mem[0] = 16'hE0A2;
    mem[1] = 16'hE0B6;
    bus.log_rd_data = '0;
    test_reset();
    test_empty();
    test_two_words();
    test_backpressure();
    test_clamp();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
